// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared state encoding, byte-enable bit indices and default bus-error timeout.
package m68k_bus_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ASSERT, S_STROBE, S_WAIT, S_LATCH, S_RELEASE, S_HOLD
  } state_t;
  localparam int BE_UPPER = 1;
  localparam int BE_LOWER = 0;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/m68k_sync2.sv
// m68k_sync2: two-flop synchroniser for an asynchronous active-low input; resets to 1 (inactive).
module m68k_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: single-outstanding 68000-style asynchronous bus master with registered strobes.
// Define M68K_BUS_MASTER_BERR_TIMEOUT_EN to enable the WAIT/HOLD bus-error timeouts.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADDR_SETUP     = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic        DTACK,
  input  logic [15:0] DATA_IN
);
  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535 || ADDR_SETUP < 1 || ADDR_SETUP > 3) begin : g_bad_param
    $error("m68k_bus_master: parameter out of range");
  end
  state_t      state, nxt;
  logic        dtack_s, err, err_nxt, rw_q, to_hit, as_on, ds_on;
  logic [1:0]  be_q, scnt;
  m68k_sync2 u_dtack_sync (.clk(CLK), .rst_n(RST), .d(DTACK), .q(dtack_s));
  assign req_ready = state == S_IDLE;
`ifdef M68K_BUS_MASTER_BERR_TIMEOUT_EN
  logic [15:0] tcnt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) tcnt <= '0;
    else      tcnt <= (nxt == state && (state == S_WAIT || state == S_HOLD)) ? tcnt + 16'd1 : '0;
  assign to_hit = tcnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    nxt = state;
    err_nxt = err;
    unique case (state)
      S_IDLE:    if (req_valid) begin nxt = S_SETUP; err_nxt = 1'b0; end
      S_SETUP:   nxt = (scnt == 2'(ADDR_SETUP - 1)) ? S_ASSERT : S_SETUP;
      S_ASSERT:  nxt = S_STROBE;
      S_STROBE:  nxt = S_WAIT;
      S_WAIT:    if (!dtack_s) nxt = S_LATCH;
                 else if (to_hit) begin nxt = S_RELEASE; err_nxt = 1'b1; end
      S_LATCH:   nxt = S_RELEASE;
      S_RELEASE: nxt = S_HOLD;
      S_HOLD:    nxt = (dtack_s || err || to_hit) ? S_IDLE : S_HOLD;
      default:   nxt = S_IDLE;
    endcase
  end
  // Strobes are registered from the next state so the bus pins never glitch on decode.
  assign as_on = nxt inside {S_ASSERT, S_STROBE, S_WAIT, S_LATCH};
  assign ds_on = (nxt inside {S_STROBE, S_WAIT, S_LATCH}) || (nxt == S_ASSERT && rw_q);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= S_IDLE;
      err <= 1'b0;
      scnt <= 2'd0;
      rw_q <= 1'b1;
      be_q <= 2'b11;
      ADDR_OUT <= '0;
      DATA_OUT <= '0;
      DATA_OE <= 1'b0;
      RW <= 1'b1;
      AS <= 1'b1;
      UDS <= 1'b1;
      LDS <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      err <= err_nxt;
      scnt <= (state == S_SETUP) ? scnt + 2'd1 : 2'd0;
      AS <= !as_on;
      UDS <= !(ds_on && be_q[BE_UPPER]);
      LDS <= !(ds_on && be_q[BE_LOWER]);
      rsp_valid <= nxt == S_RELEASE;
      rsp_err <= nxt == S_RELEASE && err_nxt;
      if (state == S_IDLE && req_valid) begin
        rw_q <= req_rw;
        be_q <= (req_be == 2'b00) ? 2'b11 : req_be;
        ADDR_OUT <= req_addr;
        DATA_OUT <= req_wdata;
        DATA_OE <= !req_rw;
        RW <= req_rw;
      end else if (state == S_RELEASE) begin
        DATA_OE <= 1'b0;
        RW <= 1'b1;
      end
      if (state == S_LATCH && rw_q) rsp_rdata <= DATA_IN;
    end
endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: S_WAIT cycles without DTACK before bus error; legal range 4..65535.
REQ-002 Parameter ADDR_SETUP, default 1: cycles ADDR_OUT/RW are stable before AS falls; legal range 1..3.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  command request.
REQ-006 req_ready  out  1  high only in IDLE; command accepted when req_valid & req_ready.
REQ-007 req_rw  in  1  1=read, 0=write.
REQ-008 req_addr  in  23  word address [23:1].
REQ-009 req_be  in  2  [1]=upper byte, [0]=lower byte; 2'b00 is illegal, treated as 2'b11.
REQ-010 req_wdata  in  16  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  16  read data; held until next rsp_valid.
REQ-013 rsp_err  out  1  qualifies rsp_valid; 1=bus timeout.
REQ-014 ADDR_OUT  out  23  bus address. REQ-015 DATA_OUT  out  16  bus write data. REQ-016 DATA_OE  out  1  data driver enable, active-high.
REQ-017 AS, UDS, LDS  out  1 each  active-low strobes. REQ-018 RW  out  1  1=read.
REQ-019 DTACK  in  1  active-low acknowledge from any responder, asynchronous to CLK. REQ-020 DATA_IN  in  16  bus read data.

Function
REQ-021 DTACK double-flopped to dtack_s before any use; DATA_IN sampled directly, one cycle after dtack_s falls.
REQ-022 States: IDLE, SETUP, ASSERT, STROBE, WAIT, LATCH, RELEASE, HOLD.
REQ-023 IDLE: on accept, latch all req_* fields, drive ADDR_OUT, RW=req_rw, DATA_OUT, DATA_OE=~req_rw; -> SETUP.
REQ-024 SETUP: held ADDR_SETUP cycles; -> ASSERT.
REQ-025 ASSERT: AS=0; reads also assert UDS/LDS = ~be this cycle; -> STROBE.
REQ-026 STROBE: writes assert UDS/LDS = ~be (one cycle after AS); -> WAIT.
REQ-027 WAIT: dtack_s==0 -> LATCH; timeout counter increments each cycle; counter == TIMEOUT_CYCLES-1 -> RELEASE with error flag set.
REQ-028 LATCH: reads capture DATA_IN into rsp_rdata; -> RELEASE.
REQ-029 RELEASE: AS, UDS, LDS=1; rsp_valid=1, rsp_err=error flag; -> HOLD.
REQ-030 HOLD: ADDR_OUT/DATA_OUT held; DATA_OE=0, RW=1 on entry; -> IDLE only when dtack_s==1 (responder released) or error flag set; HOLD also times out after TIMEOUT_CYCLES, then -> IDLE without a second rsp_valid.
REQ-031 Exactly one rsp_valid per accepted command; no new accept before IDLE.
REQ-032 rsp_rdata unchanged on writes and on errored reads.
REQ-033 dtack_s low in IDLE/SETUP (stale acknowledge) is ignored; WAIT requires it low.

Reset
REQ-034 RST low: state=IDLE; AS=UDS=LDS=RW=1; DATA_OE=0; ADDR_OUT, DATA_OUT, rsp_rdata=0; rsp_valid=rsp_err=0; counter=0; sync flops=1.
REQ-035 Reset mid-cycle releases all strobes and DATA_OE immediately (asynchronous); no rsp_valid is issued for the aborted command.

Configuration
REQ-036 Macro M68K_BUS_MASTER_BERR_TIMEOUT_EN: defined -> REQ-027/030 timeouts active; undefined -> no counter, WAIT and HOLD wait indefinitely, rsp_err tied 0.

Structure
REQ-037 Shared package m68k_bus_pkg: state enum, BE_UPPER/BE_LOWER bit indices, default TIMEOUT_CYCLES constant.
REQ-038 One sub-module, m68k_sync2 (two-flop synchroniser, reset value 1), used for DTACK.

Verification
REQ-039 Read 0x200000, be=11, responder drives DTACK low 3 cycles after AS, DATA_IN=0xBEEF -> rsp_valid once, rsp_rdata=0xBEEF, rsp_err=0.
REQ-040 Write 0x000100, data 0x1234, be=01 -> LDS falls 1 cycle after AS, UDS stays 1, DATA_OE=1 from SETUP to HOLD entry, DATA_OUT=0x1234 while AS low.
REQ-041 Read with no DTACK, TIMEOUT_CYCLES=16 -> rsp_err=1 after 16 WAIT cycles, strobes released, rsp_rdata unchanged.
REQ-042 Responder holds DTACK low 5 cycles after AS rises -> HOLD persists until dtack_s high; req_ready stays 0 throughout.
REQ-043 RST asserted while AS low -> AS/UDS/LDS=1 and DATA_OE=0 in the same cycle; no rsp_valid; next command completes normally.
REQ-044 Back-to-back: req_valid held high for 4 reads -> exactly 4 rsp_valid pulses, AS high at least 1 cycle between cycles.
